// File: rtl/postfix_evaluator.sv
// Postfix expression evaluator: pushes operands, executes one add/sub/mul per EXEC cycle, reports stack/format errors.
// Operand tokens take 1 cycle, operators 2; tok_ready is low outside IN so the producer holds its token.
module postfix_evaluator #(
   parameter int W     = 16,
   parameter int DEPTH = 8,
   parameter int SPW   = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tok_valid,
   output logic           tok_ready,
   input  logic           tok_is_op,
   input  logic [1:0]     tok_op,
   input  logic [W-1:0]   tok_val,
   input  logic           tok_last,
   output logic [W-1:0]   result,
   output logic           result_valid,
   input  logic           result_ack,
   output logic           err,
   output logic [1:0]     err_code,
   output logic           arith_ovf,
   output logic [SPW-1:0] depth
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UND  = 2'b10;
   localparam logic [1:0] ERR_MAL  = 2'b11;

   typedef enum logic [1:0] {S_IN, S_EXEC, S_DONE, S_ERR} state_t;

   state_t         state_q, state_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic [W-1:0]   result_q, result_d;
   logic [1:0]     err_code_q, err_code_d;
   logic           ovf_q, ovf_d;
   logic [1:0]     op_q, op_d;
   logic           last_q, last_d;
   logic [W-1:0]   stack_q [DEPTH];
   logic [W-1:0]   stack_d [DEPTH];

   logic [AW-1:0]  push_idx, a_idx, b_idx;
   logic [W-1:0]   a, b;
   logic [W:0]     sum_x;
   logic [2*W-1:0] prod;
   logic [W-1:0]   exec_res;
   logic           exec_ovf;

   assign push_idx = AW'(sp_q);
   assign a_idx    = AW'(sp_q - SPW'(2));
   assign b_idx    = AW'(sp_q - SPW'(1));

   // Operands are sign-extended one bit (add/sub) or to 2W bits (mul) so the
   // wrapped result and the "did not fit" flag fall out of plain unsigned math.
   always_comb begin
      a        = stack_q[a_idx];
      b        = stack_q[b_idx];
      sum_x    = '0;
      prod     = '0;
      exec_res = '0;
      exec_ovf = 1'b0;
      if (op_q == OP_SUB) begin
         sum_x = {a[W-1], a} - {b[W-1], b};
      end else begin
         sum_x = {a[W-1], a} + {b[W-1], b};
      end
      prod = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
      if (op_q == OP_MUL) begin
         exec_res = prod[W-1:0];
         exec_ovf = ~((&prod[2*W-1:W-1]) | ~(|prod[2*W-1:W-1]));
      end else begin
         exec_res = sum_x[W-1:0];
         exec_ovf = sum_x[W] ^ sum_x[W-1];
      end
   end

   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      result_d   = result_q;
      err_code_d = err_code_q;
      ovf_d      = ovf_q;
      op_d       = op_q;
      last_d     = last_q;
      stack_d    = stack_q;
      case (state_q)
         S_IN: begin
            if (tok_valid) begin
               if (!tok_is_op) begin
                  if (sp_q == SPW'(DEPTH)) begin
                     state_d    = S_ERR;
                     err_code_d = ERR_OVF;
                  end else begin
                     stack_d[push_idx] = tok_val;
                     sp_d              = sp_q + SPW'(1);
                     if (tok_last) begin
                        if (sp_q == '0) begin
                           state_d  = S_DONE;
                           result_d = tok_val;
                        end else begin
                           state_d    = S_ERR;
                           err_code_d = ERR_MAL;
                        end
                     end
                  end
               end else if (tok_op == OP_ILL) begin
                  state_d    = S_ERR;
                  err_code_d = ERR_MAL;
               end else if (sp_q < SPW'(2)) begin
                  state_d    = S_ERR;
                  err_code_d = ERR_UND;
               end else begin
                  op_d    = tok_op;
                  last_d  = tok_last;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            stack_d[a_idx] = exec_res;
            sp_d           = sp_q - SPW'(1);
            if (exec_ovf) begin
               ovf_d = 1'b1;
            end
            if (!last_q) begin
               state_d = S_IN;
            end else if (sp_q == SPW'(2)) begin
               state_d  = S_DONE;
               result_d = exec_res;
            end else begin
               state_d    = S_ERR;
               err_code_d = ERR_MAL;
            end
         end
         S_DONE, S_ERR: begin
            if (result_ack) begin
               sp_d       = '0;
               ovf_d      = 1'b0;
               err_code_d = ERR_NONE;
               state_d    = S_IN;
            end
         end
         default: state_d = S_IN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IN;
         sp_q       <= '0;
         result_q   <= '0;
         err_code_q <= ERR_NONE;
         ovf_q      <= 1'b0;
         op_q       <= 2'b00;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         result_q   <= result_d;
         err_code_q <= err_code_d;
         ovf_q      <= ovf_d;
         op_q       <= op_d;
         last_q     <= last_d;
      end
   end

   // Stack storage is never read before being written, so it carries no reset.
   always_ff @(posedge clk) begin
      stack_q <= stack_d;
   end

   assign tok_ready    = (state_q == S_IN);
   assign result       = result_q;
   assign result_valid = (state_q == S_DONE);
   assign err          = (state_q == S_ERR);
   assign err_code     = err_code_q;
   assign arith_ovf    = ovf_q;
   assign depth        = sp_q;

endmodule

// File: tb/tb_postfix_evaluator.sv
// Scoreboard bench for postfix_evaluator: expected outcomes are queued as tokens are driven, popped when the DUT reports.
module tb_postfix_evaluator;
   localparam int W = 16;
   localparam int DEPTH = 8;
   localparam int SPW = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           tok_valid = 1'b0;
   logic           tok_ready;
   logic           tok_is_op = 1'b0;
   logic [1:0]     tok_op = 2'b00;
   logic [W-1:0]   tok_val = '0;
   logic           tok_last = 1'b0;
   logic [W-1:0]   result;
   logic           result_valid;
   logic           result_ack = 1'b0;
   logic           err;
   logic [1:0]     err_code;
   logic           arith_ovf;
   logic [SPW-1:0] depth;

   typedef struct packed {
      logic         err;
      logic [1:0]   code;
      logic         ovf;
      logic [W-1:0] val;
   } exp_t;

   exp_t         sb[$];
   exp_t         e;
   int           tests = 0;
   int           fails = 0;
   int           cyc;
   logic [W-1:0] last_result = '0;

   postfix_evaluator #(.W(W), .DEPTH(DEPTH), .SPW(SPW)) dut (
      .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_is_op(tok_is_op), .tok_op(tok_op), .tok_val(tok_val), .tok_last(tok_last),
      .result(result), .result_valid(result_valid), .result_ack(result_ack),
      .err(err), .err_code(err_code), .arith_ovf(arith_ovf), .depth(depth)
   );

   always #5 clk = ~clk;

   task automatic push_ok(input logic [W-1:0] v, input logic ovf);
      sb.push_back('{err: 1'b0, code: 2'b00, ovf: ovf, val: v});
      last_result = v;
   endtask

   task automatic push_err(input logic [1:0] code);
      sb.push_back('{err: 1'b1, code: code, ovf: 1'b0, val: last_result});
   endtask

   task automatic send_tok(input logic is_op, input logic [1:0] op, input logic [W-1:0] val, input logic last);
      int n = 0;
      tok_valid = 1'b1; tok_is_op = is_op; tok_op = op; tok_val = val; tok_last = last;
      while (!tok_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!tok_ready) begin
         tests++; fails++;
         $display("FAIL send_tok_timeout tok_ready=%b required 1", tok_ready);
      end else begin
         @(posedge clk); #1;
      end
      tok_valid = 1'b0;
   endtask

   task automatic opnd(input int v, input logic last);
      send_tok(1'b0, 2'b00, W'(v), last);
   endtask

   task automatic oper(input logic [1:0] op, input logic last);
      send_tok(1'b1, op, '0, last);
   endtask

   task automatic wait_outcome(output int c);
      c = 0;
      while (!(result_valid || err) && c < 20) begin
         @(posedge clk); #1; c++;
      end
   endtask

   task automatic do_ack();
      result_ack = 1'b1;
      @(posedge clk); #1;
      result_ack = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      tests++;
      if ({result, result_valid, err, err_code, arith_ovf, depth} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got res=%0d rv=%b err=%b code=%b ovf=%b depth=%0d required all zero",
                  result, result_valid, err, err_code, arith_ovf, depth);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (tok_ready !== 1'b1) begin
         fails++; $display("FAIL reset_tok_ready got %b required 1", tok_ready);
      end
   endtask

   task automatic test_mixed_expr();
      opnd(80, 0); opnd(-25, 0); oper(2'b10, 0); opnd(334, 0); oper(2'b01, 0);
      opnd(99, 0); opnd(30, 0); oper(2'b10, 0);
      push_ok(W'(80 * -25 - 334 + 99 * 30), 1'b0);
      oper(2'b00, 1);
      wait_outcome(cyc);
      e = sb.pop_front();
      tests++;
      if ({result_valid, err, err_code, arith_ovf, result} !== {~e.err, e.err, e.code, e.ovf, e.val}) begin
         fails++;
         $display("FAIL mixed_outcome got rv=%b err=%b code=%b ovf=%b res=%0d required err=%b code=%b ovf=%b res=%0d",
                  result_valid, err, err_code, arith_ovf, $signed(result), e.err, e.code, e.ovf, $signed(e.val));
      end
      tests++;
      if (cyc != 1 || depth !== SPW'(1)) begin
         fails++; $display("FAIL mixed_latency_depth got cyc=%0d depth=%0d required cyc=1 depth=1", cyc, depth);
      end
      do_ack();
      tests++;
      if (depth !== '0 || result_valid !== 1'b0 || tok_ready !== 1'b1) begin
         fails++; $display("FAIL mixed_ack got depth=%0d rv=%b rdy=%b required 0 0 1", depth, result_valid, tok_ready);
      end
   endtask

   task automatic test_stack_overflow();
      for (int i = 1; i <= DEPTH; i++) opnd(i, 0);
      push_err(2'b01);
      opnd(DEPTH + 1, 0);
      wait_outcome(cyc);
      e = sb.pop_front();
      tests++;
      if ({result_valid, err, err_code, arith_ovf, result} !== {~e.err, e.err, e.code, e.ovf, e.val}) begin
         fails++;
         $display("FAIL stkovf_outcome got rv=%b err=%b code=%b ovf=%b res=%0d required err=%b code=%b ovf=%b res=%0d",
                  result_valid, err, err_code, arith_ovf, $signed(result), e.err, e.code, e.ovf, $signed(e.val));
      end
      tests++;
      if (depth !== SPW'(DEPTH)) begin
         fails++; $display("FAIL stkovf_depth got %0d required %0d", depth, DEPTH);
      end
      do_ack();
      tests++;
      if (depth !== '0 || err !== 1'b0 || err_code !== 2'b00 || tok_ready !== 1'b1) begin
         fails++; $display("FAIL stkovf_ack got depth=%0d err=%b code=%b rdy=%b required 0 0 00 1", depth, err, err_code, tok_ready);
      end
   endtask

   task automatic test_underflow();
      opnd(5, 0);
      push_err(2'b10);
      oper(2'b00, 1);
      wait_outcome(cyc);
      e = sb.pop_front();
      tests++;
      if ({result_valid, err, err_code, arith_ovf, result} !== {~e.err, e.err, e.code, e.ovf, e.val}) begin
         fails++;
         $display("FAIL underflow_outcome got rv=%b err=%b code=%b ovf=%b res=%0d required err=%b code=%b ovf=%b res=%0d",
                  result_valid, err, err_code, arith_ovf, $signed(result), e.err, e.code, e.ovf, $signed(e.val));
      end
      do_ack();
   endtask

   task automatic test_malformed();
      opnd(1, 0);
      push_err(2'b11);
      opnd(2, 1);
      wait_outcome(cyc);
      e = sb.pop_front();
      tests++;
      if ({result_valid, err, err_code, result} !== {~e.err, e.err, e.code, e.val}) begin
         fails++;
         $display("FAIL malformed_last got rv=%b err=%b code=%b res=%0d required err=%b code=%b res=%0d",
                  result_valid, err, err_code, $signed(result), e.err, e.code, $signed(e.val));
      end
      do_ack();
      opnd(4, 0);
      push_err(2'b11);
      oper(2'b11, 0);
      wait_outcome(cyc);
      e = sb.pop_front();
      tests++;
      if ({result_valid, err, err_code, result} !== {~e.err, e.err, e.code, e.val}) begin
         fails++;
         $display("FAIL illegal_op got rv=%b err=%b code=%b res=%0d required err=%b code=%b res=%0d",
                  result_valid, err, err_code, $signed(result), e.err, e.code, $signed(e.val));
      end
      do_ack();
   endtask

   task automatic test_arith_wrap();
      opnd(200, 0); opnd(200, 0);
      push_ok(W'(200 * 200), 1'b1);
      oper(2'b10, 1);
      wait_outcome(cyc);
      e = sb.pop_front();
      tests++;
      if ({result_valid, err, err_code, arith_ovf, result} !== {~e.err, e.err, e.code, e.ovf, e.val}) begin
         fails++;
         $display("FAIL wrap_outcome got rv=%b err=%b code=%b ovf=%b res=%0d required err=%b code=%b ovf=%b res=%0d",
                  result_valid, err, err_code, arith_ovf, $signed(result), e.err, e.code, e.ovf, $signed(e.val));
      end
      do_ack();
      tests++;
      if (arith_ovf !== 1'b0) begin
         fails++; $display("FAIL wrap_ovf_clear got %b required 0", arith_ovf);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] a, b, r;
         logic [1:0]   op;
         longint       ex;
         a  = W'($urandom);
         b  = W'($urandom);
         op = 2'($urandom_range(0, 2));
         if (i < 3) begin
            a = W'(32767); b = W'(i == 2 ? -1 : 1);
         end
         case (op)
            2'b00:   ex = longint'($signed(a)) + longint'($signed(b));
            2'b01:   ex = longint'($signed(a)) - longint'($signed(b));
            default: ex = longint'($signed(a)) * longint'($signed(b));
         endcase
         r = ex[W-1:0];
         push_ok(r, (ex > 32767 || ex < -32768));
         send_tok(1'b0, 2'b00, a, 1'b0);
         send_tok(1'b0, 2'b00, b, 1'b0);
         oper(op, 1);
         wait_outcome(cyc);
         e = sb.pop_front();
         tests++;
         if ({result_valid, err, err_code, arith_ovf, result} !== {~e.err, e.err, e.code, e.ovf, e.val}) begin
            fails++;
            $display("FAIL b2b_%0d a=%0d b=%0d op=%0d got rv=%b err=%b ovf=%b res=%0d required ovf=%b res=%0d", i,
                     $signed(a), $signed(b), op, result_valid, err, arith_ovf, $signed(result), e.ovf, $signed(e.val));
         end
         do_ack();
      end
   endtask

   task automatic test_reset_mid();
      opnd(3, 0);
      rst = 1'b1;
      #2;
      tests++;
      if ({result, result_valid, err, err_code, arith_ovf, depth} !== '0) begin
         fails++;
         $display("FAIL midrst_outputs got res=%0d rv=%b err=%b code=%b ovf=%b depth=%0d required all zero",
                  result, result_valid, err, err_code, arith_ovf, depth);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      push_ok(W'(7), 1'b0);
      opnd(7, 1);
      wait_outcome(cyc);
      e = sb.pop_front();
      tests++;
      if ({result_valid, err, result, depth} !== {1'b1, 1'b0, e.val, SPW'(1)} || cyc != 0) begin
         fails++;
         $display("FAIL midrst_next got rv=%b err=%b res=%0d depth=%0d cyc=%0d required 1 0 %0d 1 0",
                  result_valid, err, $signed(result), depth, cyc, $signed(e.val));
      end
      do_ack();
   endtask

   task automatic test_hold_valid();
      opnd(3, 0); opnd(4, 0);
      push_ok(W'(3 + 4), 1'b0);
      tok_valid = 1'b1; tok_is_op = 1'b1; tok_op = 2'b00; tok_last = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (tok_ready !== 1'b0 || depth !== SPW'(2)) begin
         fails++; $display("FAIL hold_exec got rdy=%b depth=%0d required 0 2", tok_ready, depth);
      end
      tok_is_op = 1'b0; tok_val = W'(9); tok_last = 1'b1;
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (tok_ready !== 1'b0 || result_valid !== 1'b1 || result !== e.val || depth !== SPW'(1)) begin
         fails++;
         $display("FAIL hold_done got rdy=%b rv=%b res=%0d depth=%0d required 0 1 %0d 1", tok_ready, result_valid,
                  $signed(result), depth, $signed(e.val));
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
      tests++;
      if (tok_ready !== 1'b0 || result_valid !== 1'b1 || depth !== SPW'(1)) begin
         fails++; $display("FAIL hold_wait got rdy=%b rv=%b depth=%0d required 0 1 1", tok_ready, result_valid, depth);
      end
      push_ok(W'(9), 1'b0);
      do_ack();
      tests++;
      if (tok_ready !== 1'b1 || depth !== '0) begin
         fails++; $display("FAIL hold_ack got rdy=%b depth=%0d required 1 0", tok_ready, depth);
      end
      @(posedge clk); #1;
      tok_valid = 1'b0;
      e = sb.pop_front();
      tests++;
      if (result_valid !== 1'b1 || result !== e.val || depth !== SPW'(1)) begin
         fails++; $display("FAIL hold_replay got rv=%b res=%0d depth=%0d required 1 %0d 1", result_valid,
                           $signed(result), depth, $signed(e.val));
      end
      do_ack();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mixed_expr();
      test_stack_overflow();
      test_underflow();
      test_malformed();
      test_arith_wrap();
      test_back_to_back();
      test_reset_mid();
      test_hold_valid();
      tests++;
      if (sb.size() != 0) begin
         fails++; $display("FAIL scoreboard_leftover got %0d required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
